baud_rate_generator: RTL and testbench
======================================

# baud_rate_generator

Parametrised fractional baud-rate generator for the UART transmitter/receiver pair. It replaces the fixed-divisor baud controller. A phase accumulator produces an oversampling strobe whose average rate is exact for any system clock. It adds a bit-rate strobe for the transmitter, a mid-bit strobe and sample index for the receiver, a resync input for start-bit alignment, and clean handling of run-time rate changes.

## Interface
- CLK_FREQ_HZ, 50_000_000: system clock frequency; must exceed 115200*OVERSAMPLE (elaboration error otherwise).
- OVERSAMPLE, 16: sample strobes per bit; power of two, 4..64.
- ACC_WIDTH, 27: accumulator width; must hold CLK_FREQ_HZ + 115200*OVERSAMPLE - 1 (elaboration check).
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run control; when low, all state holds and strobes are 0.
- resync  in  1  synchronous realignment (receiver start-edge detect).
- baud_select  in  3  rate code: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200 baud.
- sample_ENABLE  out  1  one-cycle oversampling strobe, average rate baud*OVERSAMPLE.
- tx_ENABLE  out  1  one-cycle bit-rate strobe, every OVERSAMPLE-th sample strobe.
- mid_ENABLE  out  1  one-cycle mid-bit strobe (sample index reaching OVERSAMPLE/2).
- sample_index  out  log2(OVERSAMPLE)  position of the current sample within the bit.

## Operation
- Increment INC = rate(sel_q)*OVERSAMPLE, from a constant table indexed by the registered select sel_q.
- Reset (async): acc=0, idx=0, sel_q=baud_select is not captured; sel_q=3'b000. All strobes=0. sample_index=0.
- Priority per clock edge, highest first: resync, rate change, enable.
- resync=1: acc<=0, idx<=0, all strobes<=0. sel_q is unchanged.
- Rate change (baud_select != sel_q, resync=0): sel_q<=baud_select, acc<=0, idx<=0, strobes<=0. Enable is ignored in that cycle. The first cycle after reset release with baud_select!=0 is a rate change.
- enable=0: acc, idx and sel_q hold; strobes<=0.
- enable=1: sum = acc + INC, computed in ACC_WIDTH+1 bits.
  - sum >= CLK_FREQ_HZ: acc<=sum-CLK_FREQ_HZ and sample_ENABLE<=1.
  - Otherwise: acc<=sum and sample_ENABLE<=0.
- On a sample pulse:
  - idx==OVERSAMPLE-1: idx<=0 and tx_ENABLE<=1.
  - Otherwise: idx<=idx+1.
  - mid_ENABLE<=1 when the new idx equals OVERSAMPLE/2.
- tx_ENABLE and mid_ENABLE are only ever high in a cycle where sample_ENABLE is high.
- sample_index = idx register, updated in the same edge as the strobes.
- Accumulator invariant: 0 <= acc < CLK_FREQ_HZ at all times. No wrap-around or overflow is permitted.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Strobe latency: a strobe is visible for exactly one cycle, starting at the edge on which sum crosses CLK_FREQ_HZ.
- The first sample strobe after reset/resync/rate change occurs on the ceil(CLK_FREQ_HZ/INC)-th enabled cycle.
- Strobe spacing is floor or ceil of CLK_FREQ_HZ/INC cycles.
  - Default clock, 115200 baud: 27 or 28 cycles.
  - Default clock, 9600 baud: 325 or 326 cycles.
- Long-run count: exactly floor(N*INC/CLK_FREQ_HZ) strobes over N enabled cycles from acc=0.
- Reset asserted mid-bit clears everything immediately, without waiting for a clock edge.
- Removing reset starts counting on the first edge with reset low.
- resync asserted in the same cycle as a would-be strobe: resync wins and no strobe is emitted.
- Rate change while enable=0 still clears acc/idx.

## Test plan
- Reset release with baud_select=7, enable=1 (defaults) -> first sample_ENABLE on enabled cycle 28. The 16th sample strobe also asserts tx_ENABLE; the 8th asserts mid_ENABLE with sample_index=8.
- baud_select=7, 1,000,000 enabled cycles -> exactly 36,864 sample_ENABLE and 2,304 tx_ENABLE pulses; every spacing is 27 or 28.
- baud_select=3 -> sample spacing 325/326 cycles.
  - Switch to 6 mid-bit -> next cycle acc=0, sample_index=0, no strobe.
  - First new strobe on enabled cycle 55 after the clear (ceil(50e6/921600)).
- resync pulsed when sample_index=5 -> sample_index=0 next cycle.
  - A strobe due in that cycle is suppressed.
  - The next tx_ENABLE is exactly 16 sample strobes later.
- enable low for 100 cycles mid-bit -> zero strobes, acc and sample_index frozen; counting resumes from the frozen state when enable returns high.
- Asynchronous reset asserted between clock edges during a tx_ENABLE cycle -> all outputs 0 before the next edge; after release, sel_q=0 (300 baud) or a rate-change clear occurs.

Source files
------------

// File: rtl/baud_rate_generator_if.sv
// Control and strobe bundle between the baud-rate generator and the UART
// transmitter/receiver that consume its strobes.
interface baud_rate_generator_if #(
  parameter int OVERSAMPLE = 16
);
  logic                          enable;
  logic                          resync;
  logic [2:0]                    baud_select;
  logic                          sample_ENABLE;
  logic                          tx_ENABLE;
  logic                          mid_ENABLE;
  logic [$clog2(OVERSAMPLE)-1:0] sample_index;

  modport master (
    output enable, resync, baud_select,
    input  sample_ENABLE, tx_ENABLE, mid_ENABLE, sample_index
  );

  modport slave (
    input  enable, resync, baud_select,
    output sample_ENABLE, tx_ENABLE, mid_ENABLE, sample_index
  );
endinterface

// File: rtl/baud_rate_generator.sv
// Fractional baud-rate generator: a phase accumulator yields an oversampling
// strobe with exact average rate, plus bit-rate and mid-bit strobes.
module baud_rate_generator #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int OVERSAMPLE  = 16,
  parameter int ACC_WIDTH   = 27
) (
  input logic                   clk,
  input logic                   reset,
  baud_rate_generator_if.slave  bus
);

  localparam int                 IDX_W    = $clog2(OVERSAMPLE);
  localparam logic [ACC_WIDTH:0] CLK_F    = (ACC_WIDTH+1)'(CLK_FREQ_HZ);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]   IDX_MID  = IDX_W'(OVERSAMPLE / 2);

  if (longint'(CLK_FREQ_HZ) <= longint'(115200) * longint'(OVERSAMPLE)) begin : g_bad_clk
    $error("CLK_FREQ_HZ must exceed 115200*OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("OVERSAMPLE must be a power of two in 4..64");
  end
  if (longint'(CLK_FREQ_HZ) + longint'(115200) * longint'(OVERSAMPLE) - 1
      >= (longint'(1) << ACC_WIDTH)) begin : g_bad_acc
    $error("ACC_WIDTH too small for CLK_FREQ_HZ + max increment");
  end

  // Phase increment per clock: baud * OVERSAMPLE.
  function automatic logic [ACC_WIDTH-1:0] rate_inc(input logic [2:0] sel);
    logic [31:0] baud;
    case (sel)
      3'd0:    baud = 32'd300;
      3'd1:    baud = 32'd1200;
      3'd2:    baud = 32'd4800;
      3'd3:    baud = 32'd9600;
      3'd4:    baud = 32'd19200;
      3'd5:    baud = 32'd38400;
      3'd6:    baud = 32'd57600;
      default: baud = 32'd115200;
    endcase
    return ACC_WIDTH'(baud * 32'(OVERSAMPLE));
  endfunction

  logic [ACC_WIDTH-1:0] acc,   acc_d;
  logic [IDX_W-1:0]     idx,   idx_d;
  logic [2:0]           sel_q, sel_d;
  logic                 sample_q, sample_d;
  logic                 tx_q,     tx_d;
  logic                 mid_q,    mid_d;
  logic [ACC_WIDTH:0]   sum;

  // Next state: resync beats a rate change, which beats enable.
  always_comb begin
    sel_d    = sel_q;
    acc_d    = acc;
    idx_d    = idx;
    sample_d = 1'b0;
    tx_d     = 1'b0;
    mid_d    = 1'b0;
    sum      = {1'b0, acc} + {1'b0, rate_inc(sel_q)};
    if (bus.resync) begin
      acc_d = '0;
      idx_d = '0;
    end else if (bus.baud_select != sel_q) begin
      sel_d = bus.baud_select;
      acc_d = '0;
      idx_d = '0;
    end else if (bus.enable) begin
      if (sum >= CLK_F) begin
        acc_d    = ACC_WIDTH'(sum - CLK_F);
        sample_d = 1'b1;
        if (idx == IDX_LAST) begin
          idx_d = '0;
          tx_d  = 1'b1;
        end else begin
          idx_d = idx + IDX_W'(1);
        end
        mid_d = (idx_d == IDX_MID);
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
    end
  end

  // State and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      idx      <= '0;
      sel_q    <= 3'b000;
      sample_q <= 1'b0;
      tx_q     <= 1'b0;
      mid_q    <= 1'b0;
    end else begin
      acc      <= acc_d;
      idx      <= idx_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      tx_q     <= tx_d;
      mid_q    <= mid_d;
    end
  end

  assign bus.sample_ENABLE = sample_q;
  assign bus.tx_ENABLE     = tx_q;
  assign bus.mid_ENABLE    = mid_q;
  assign bus.sample_index  = idx;

endmodule

// File: tb/tb_baud_rate_generator.sv
// Directed bench for baud_rate_generator: strobe timing, rate changes,
// resync, enable hold and asynchronous reset.
module tb_baud_rate_generator;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  baud_rate_generator_if #(.OVERSAMPLE(16)) bus ();

  baud_rate_generator #(
    .CLK_FREQ_HZ(50_000_000),
    .OVERSAMPLE (16),
    .ACC_WIDTH  (27)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the next sample strobe, capped at budget.
  task automatic wait_sample(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.sample_ENABLE && n < budget);
  endtask

  initial begin
    int n, k, bad, samples, txs, last;
    bit found;

    reset           = 1'b1;
    bus.enable      = 1'b1;
    bus.resync      = 1'b0;
    bus.baud_select = 3'd7;
    repeat (2) tick();
    chk("rst_sample", 32'(bus.sample_ENABLE), 0);
    chk("rst_tx",     32'(bus.tx_ENABLE),     0);
    chk("rst_mid",    32'(bus.mid_ENABLE),    0);
    chk("rst_idx",    32'(bus.sample_index),  0);

    // Release with select 7: first edge is a rate change from 300 baud.
    reset = 1'b0;
    tick();
    chk("rel_ratechg_sample", 32'(bus.sample_ENABLE), 0);
    chk("rel_ratechg_idx",    32'(bus.sample_index),  0);
    wait_sample(100, n);
    chk("first_strobe_115200", 32'(n), 28);
    chk("first_idx",           32'(bus.sample_index), 1);
    bad = 0;
    for (int j = 2; j <= 16; j++) begin
      wait_sample(100, n);
      if (n != 27 && n != 28) bad++;
      if (j == 8) begin
        chk("mid_at_8",  32'(bus.mid_ENABLE),   1);
        chk("idx_at_8",  32'(bus.sample_index), 8);
      end else if (bus.mid_ENABLE) bad++;
      if (j == 16) begin
        chk("tx_at_16",  32'(bus.tx_ENABLE),    1);
        chk("idx_at_16", 32'(bus.sample_index), 0);
      end else if (bus.tx_ENABLE) bad++;
    end
    chk("bit_spacing_115200", 32'(bad), 0);

    // Long run from acc=0: floor(10000*1843200/50e6)=368 samples, 23 bits.
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    chk("resync_idx", 32'(bus.sample_index), 0);
    samples = 0; txs = 0; last = 0; bad = 0;
    for (int c = 1; c <= 10000; c++) begin
      tick();
      if ((bus.tx_ENABLE || bus.mid_ENABLE) && !bus.sample_ENABLE) bad++;
      if (bus.sample_ENABLE) begin
        samples++;
        if (last > 0 && (c - last) != 27 && (c - last) != 28) bad++;
        last = c;
      end
      if (bus.tx_ENABLE) txs++;
    end
    chk("long_samples",  32'(samples), 368);
    chk("long_tx",       32'(txs),     23);
    chk("long_spacing",  32'(bad),     0);
    chk("long_idx",      32'(bus.sample_index), 0);

    // 9600 baud.
    bus.baud_select = 3'd3;
    tick();
    chk("chg9600_sample", 32'(bus.sample_ENABLE), 0);
    chk("chg9600_idx",    32'(bus.sample_index),  0);
    wait_sample(400, n);
    chk("first_strobe_9600", 32'(n), 326);
    bad = 0;
    for (int j = 0; j < 4; j++) begin
      wait_sample(400, n);
      if (n != 325 && n != 326) bad++;
    end
    chk("spacing_9600", 32'(bad), 0);
    chk("idx_9600",     32'(bus.sample_index), 5);

    // Mid-bit switch to 57600.
    bus.baud_select = 3'd6;
    tick();
    chk("chg57600_sample", 32'(bus.sample_ENABLE), 0);
    chk("chg57600_idx",    32'(bus.sample_index),  0);
    wait_sample(100, n);
    chk("first_strobe_57600", 32'(n), 55);
    k = n;
    for (int j = 2; j <= 5; j++) begin
      wait_sample(100, n);
      k += n;
    end
    chk("fifth_strobe_cycle", 32'(k), 272);
    chk("fifth_strobe_idx",   32'(bus.sample_index), 5);

    // Resync on the edge where the 6th strobe (cycle 326) would land.
    repeat (53) tick();
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    chk("resync_suppress", 32'(bus.sample_ENABLE), 0);
    chk("resync_idx_clr",  32'(bus.sample_index),  0);
    k = 0; bad = 0;
    for (int j = 1; j <= 16; j++) begin
      wait_sample(100, n);
      k += n;
      if (j < 16 && bus.tx_ENABLE) bad++;
    end
    chk("resync_tx_16th",   32'(bus.tx_ENABLE), 1);
    chk("resync_early_tx",  32'(bad), 0);
    chk("resync_tx_cycle",  32'(k),   869);
    for (int j = 17; j <= 19; j++) begin
      wait_sample(100, n);
      k += n;
    end
    chk("strobe19_cycle", 32'(k), 1031);

    // Enable low for 100 cycles mid-bit.
    repeat (10) tick();
    bus.enable = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.sample_ENABLE || bus.tx_ENABLE || bus.mid_ENABLE) bad++;
      if (bus.sample_index != 4'd3) bad++;
    end
    chk("hold_frozen", 32'(bad), 0);
    bus.enable = 1'b1;
    wait_sample(100, n);
    chk("resume_gap", 32'(n), 45);
    chk("resume_idx", 32'(bus.sample_index), 4);

    // Asynchronous reset during a tx_ENABLE cycle.
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      tick();
      if (bus.tx_ENABLE) found = 1'b1;
    end
    chk("tx_seen", 32'(found), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_sample", 32'(bus.sample_ENABLE), 0);
    chk("async_tx",     32'(bus.tx_ENABLE),     0);
    chk("async_mid",    32'(bus.mid_ENABLE),    0);
    chk("async_idx",    32'(bus.sample_index),  0);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_chg_sample", 32'(bus.sample_ENABLE), 0);
    wait_sample(100, n);
    chk("post_rst_first_57600", 32'(n), 55);

    // Reset then release with select 0: no rate change, 300 baud.
    reset = 1'b1;
    tick();
    bus.baud_select = 3'd0;
    reset = 1'b0;
    wait_sample(11000, n);
    chk("first_strobe_300", 32'(n), 10417);
    chk("idx_300",          32'(bus.sample_index), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
